// File: rtl/bp_core_stall_profiler_if.sv
// Probe, control and readout bundle for the stall-attribution profiler.
// The master drives the probes and the select; the slave returns the selected counter.
interface bp_core_stall_profiler_if #(parameter int cnt_width_p = 64);
  logic freeze_i, clear_i, commit_v_i;
  logic exception_i, eret_i, interrupt_i, mispredict_i;
  logic dcache_rollback_i, dcache_miss_i, dtlb_miss_i, long_haz_i;
  logic struct_haz_i, load_dep_i, mul_dep_i, data_haz_i;
  logic control_haz_i, fe_cmd_fence_i, fe_cmd_i, icache_rollback_i;
  logic icache_miss_i, itlb_miss_i, icache_fence_i, branch_override_i;
  logic ret_override_i, fe_queue_stall_i, fe_wait_stall_i;
  logic [4:0]             sel_i;
  logic [cnt_width_p-1:0] cnt_o;

  modport master (
    output freeze_i, clear_i, commit_v_i,
    output exception_i, eret_i, interrupt_i, mispredict_i,
    output dcache_rollback_i, dcache_miss_i, dtlb_miss_i, long_haz_i,
    output struct_haz_i, load_dep_i, mul_dep_i, data_haz_i,
    output control_haz_i, fe_cmd_fence_i, fe_cmd_i, icache_rollback_i,
    output icache_miss_i, itlb_miss_i, icache_fence_i, branch_override_i,
    output ret_override_i, fe_queue_stall_i, fe_wait_stall_i,
    output sel_i,
    input  cnt_o
  );

  modport slave (
    input  freeze_i, clear_i, commit_v_i,
    input  exception_i, eret_i, interrupt_i, mispredict_i,
    input  dcache_rollback_i, dcache_miss_i, dtlb_miss_i, long_haz_i,
    input  struct_haz_i, load_dep_i, mul_dep_i, data_haz_i,
    input  control_haz_i, fe_cmd_fence_i, fe_cmd_i, icache_rollback_i,
    input  icache_miss_i, itlb_miss_i, icache_fence_i, branch_override_i,
    input  ret_override_i, fe_queue_stall_i, fe_wait_stall_i,
    input  sel_i,
    output cnt_o
  );
endinterface

// File: rtl/bp_core_stall_profiler.sv
// Credits every unfrozen cycle to either a retiring instruction or the
// highest-priority stall probe (bucket 23 when none), with a registered readout mux.
module bp_core_stall_profiler #(
  parameter int cnt_width_p = 64
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_core_stall_profiler_if.slave bus
);
  localparam int num_probe_lp = 23;
  localparam int num_stall_lp = 24;
  localparam logic [cnt_width_p-1:0] one_lp = cnt_width_p'(1);

  logic [num_probe_lp-1:0] probe;
  assign probe = {
    bus.fe_wait_stall_i, bus.fe_queue_stall_i, bus.ret_override_i, bus.branch_override_i,
    bus.icache_fence_i, bus.itlb_miss_i, bus.icache_miss_i, bus.icache_rollback_i,
    bus.fe_cmd_i, bus.fe_cmd_fence_i, bus.control_haz_i, bus.data_haz_i,
    bus.mul_dep_i, bus.load_dep_i, bus.struct_haz_i, bus.long_haz_i,
    bus.dtlb_miss_i, bus.dcache_miss_i, bus.dcache_rollback_i, bus.mispredict_i,
    bus.interrupt_i, bus.eret_i, bus.exception_i
  };

  // One-hot bucket select; a retiring instruction suppresses all stall buckets.
  logic [num_stall_lp-1:0] stall_inc;
  logic                    hit;
  always_comb begin
    stall_inc = '0;
    hit       = 1'b0;
    for (int k = 0; k < num_probe_lp; k++) begin
      if (!hit && probe[k]) begin
        stall_inc[k] = 1'b1;
        hit          = 1'b1;
      end
    end
    if (!hit) stall_inc[num_stall_lp-1] = 1'b1;
    if (bus.commit_v_i) stall_inc = '0;
  end

  logic [num_stall_lp-1:0][cnt_width_p-1:0] stall_q;
  logic [cnt_width_p-1:0]                   cycle_q, instr_q, sel_val, cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else if (bus.clear_i) begin
      stall_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else if (!bus.freeze_i) begin
      cycle_q <= cycle_q + one_lp;
      if (bus.commit_v_i) instr_q <= instr_q + one_lp;
      for (int k = 0; k < num_stall_lp; k++)
        if (stall_inc[k]) stall_q[k] <= stall_q[k] + one_lp;
    end
  end

  always_comb begin
    sel_val = '0;
    if (bus.sel_i < 5'd24)       sel_val = stall_q[bus.sel_i];
    else if (bus.sel_i == 5'd24) sel_val = cycle_q;
    else if (bus.sel_i == 5'd25) sel_val = instr_q;
  end

  // Readout samples pre-edge counter values, so it trails counting by one edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= sel_val;
  end

  assign bus.cnt_o = cnt_q;
endmodule

// File: tb/tb_bp_core_stall_profiler.sv
// Directed and reference-model checks of the stall profiler, plus a narrow
// instance for counter wrap.
module tb_bp_core_stall_profiler;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bp_core_stall_profiler_if #(.cnt_width_p(64)) bus  ();
  bp_core_stall_profiler_if #(.cnt_width_p(4))  bus4 ();

  bp_core_stall_profiler #(.cnt_width_p(64)) dut  (.clk_i(clk), .reset_n_i(reset_n), .bus(bus));
  bp_core_stall_profiler #(.cnt_width_p(4))  dut4 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus4));

  int total = 0;
  int bad   = 0;

  logic [63:0] m_st [24];
  logic [63:0] m_cyc, m_ins;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input logic [22:0] p);
    bus.exception_i       = p[0];  bus.eret_i            = p[1];
    bus.interrupt_i       = p[2];  bus.mispredict_i      = p[3];
    bus.dcache_rollback_i = p[4];  bus.dcache_miss_i     = p[5];
    bus.dtlb_miss_i       = p[6];  bus.long_haz_i        = p[7];
    bus.struct_haz_i      = p[8];  bus.load_dep_i        = p[9];
    bus.mul_dep_i         = p[10]; bus.data_haz_i        = p[11];
    bus.control_haz_i     = p[12]; bus.fe_cmd_fence_i    = p[13];
    bus.fe_cmd_i          = p[14]; bus.icache_rollback_i = p[15];
    bus.icache_miss_i     = p[16]; bus.itlb_miss_i       = p[17];
    bus.icache_fence_i    = p[18]; bus.branch_override_i = p[19];
    bus.ret_override_i    = p[20]; bus.fe_queue_stall_i  = p[21];
    bus.fe_wait_stall_i   = p[22];
  endtask

  task automatic set4_idle();
    bus4.exception_i = 0; bus4.eret_i = 0; bus4.interrupt_i = 0; bus4.mispredict_i = 0;
    bus4.dcache_rollback_i = 0; bus4.dcache_miss_i = 0; bus4.dtlb_miss_i = 0; bus4.long_haz_i = 0;
    bus4.struct_haz_i = 0; bus4.load_dep_i = 0; bus4.mul_dep_i = 0; bus4.data_haz_i = 0;
    bus4.control_haz_i = 0; bus4.fe_cmd_fence_i = 0; bus4.fe_cmd_i = 0; bus4.icache_rollback_i = 0;
    bus4.icache_miss_i = 0; bus4.itlb_miss_i = 0; bus4.icache_fence_i = 0; bus4.branch_override_i = 0;
    bus4.ret_override_i = 0; bus4.fe_queue_stall_i = 0; bus4.fe_wait_stall_i = 0;
    bus4.commit_v_i = 0; bus4.clear_i = 0; bus4.freeze_i = 1; bus4.sel_i = '0;
  endtask

  // Frozen one-edge read: cnt_o after the edge is the selected counter's held value.
  task automatic rd(input bit w, input logic [4:0] s, input logic [63:0] exp, input string tag);
    bus.freeze_i = 1'b1; bus.clear_i = 1'b0;
    bus4.freeze_i = 1'b1; bus4.clear_i = 1'b0;
    if (w) bus4.sel_i = s; else bus.sel_i = s;
    tick();
    chk(tag, w ? 64'(bus4.cnt_o) : bus.cnt_o, exp);
  endtask

  task automatic do_clear();
    bus.clear_i = 1'b1; bus.freeze_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  function automatic logic [63:0] m_sel(input logic [4:0] s);
    if (s < 5'd24)  return m_st[s];
    if (s == 5'd24) return m_cyc;
    if (s == 5'd25) return m_ins;
    return 64'd0;
  endfunction

  task automatic m_zero();
    for (int k = 0; k < 24; k++) m_st[k] = '0;
    m_cyc = '0;
    m_ins = '0;
  endtask

  logic [22:0] p;
  logic [63:0] got [26];
  logic [63:0] exp_v, sum;
  logic        cm, fz, cl;
  logic [4:0]  sl;
  int          kk;

  initial begin
    reset_n = 1'b0;
    setp('0);
    bus.commit_v_i = 0; bus.clear_i = 0; bus.freeze_i = 1; bus.sel_i = '0;
    set4_idle();

    // reset held while the select sweeps every counter
    for (int s = 0; s < 26; s++) begin
      bus.sel_i = 5'(s);
      tick();
      chk($sformatf("rst_sel%0d", s), bus.cnt_o, 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rd(0, 24, 64'd0, "frozen_cyc");

    // priority: dcache_miss outranks data_haz and fe_wait_stall
    p = '0; p[5] = 1; p[11] = 1; p[22] = 1;
    setp(p); bus.freeze_i = 0;
    for (int i = 0; i < 5; i++) tick();
    setp('0);
    rd(0, 5,  64'd5, "prio_st5");
    rd(0, 11, 64'd0, "prio_st11");
    rd(0, 22, 64'd0, "prio_st22");
    rd(0, 24, 64'd5, "prio_cyc");

    // commit wins over exception
    do_clear();
    p = '0; p[0] = 1;
    setp(p); bus.commit_v_i = 1; bus.freeze_i = 0;
    for (int i = 0; i < 4; i++) tick();
    setp('0); bus.commit_v_i = 0;
    for (int i = 0; i < 2; i++) tick();
    rd(0, 25, 64'd4, "cmt_ins");
    rd(0, 0,  64'd0, "cmt_st0");
    rd(0, 23, 64'd2, "cmt_st23");
    rd(0, 24, 64'd6, "cmt_cyc");

    // clear beats a same-edge commit
    do_clear();
    bus.freeze_i = 0;
    for (int i = 0; i < 100; i++) tick();
    bus.clear_i = 1; bus.commit_v_i = 1; bus.sel_i = 24;
    tick();
    chk("clr_pre_cnt", bus.cnt_o, 64'd100);
    bus.commit_v_i = 0;
    rd(0, 24, 64'd0, "clr_cyc");
    for (int s = 0; s < 26; s++) rd(0, 5'(s), 64'd0, $sformatf("clr_sel%0d", s));

    // 4-bit instance: 17 idle cycles wrap to 1
    bus4.freeze_i = 0;
    for (int i = 0; i < 17; i++) tick();
    rd(1, 24, 64'd1, "wrap_cyc");
    rd(1, 23, 64'd1, "wrap_st23");
    rd(1, 30, 64'd0, "wrap_sel30");

    // random traffic against the reference model
    do_clear();
    m_zero();
    for (int c = 0; c < 10000; c++) begin
      p = '0;
      for (int k = 0; k < 23; k++) if ($urandom_range(15) == 0) p[k] = 1'b1;
      cm = ($urandom_range(2) == 0);
      fz = ($urandom_range(7) == 0);
      cl = ($urandom_range(499) == 0);
      sl = 5'($urandom_range(31));
      setp(p);
      bus.commit_v_i = cm; bus.freeze_i = fz; bus.clear_i = cl; bus.sel_i = sl;
      exp_v = m_sel(sl);
      tick();
      chk("rand_cnt", bus.cnt_o, exp_v);
      if (cl) m_zero();
      else if (!fz) begin
        m_cyc++;
        if (cm) m_ins++;
        else begin
          kk = 23;
          for (int k = 22; k >= 0; k--) if (p[k]) kk = k;
          m_st[kk]++;
        end
      end
      if (c == 5000) begin
        reset_n = 1'b0;
        #1;
        chk("arst_cnt", bus.cnt_o, 64'd0);
        m_zero();
        #2;
        reset_n = 1'b1;
        rd(0, 24, 64'd0, "arst_cyc");
        rd(0, 25, 64'd0, "arst_ins");
      end
    end

    setp('0); bus.commit_v_i = 0;
    for (int s = 0; s < 26; s++) begin
      rd(0, 5'(s), m_sel(5'(s)), $sformatf("final_sel%0d", s));
      got[s] = bus.cnt_o;
    end
    sum = got[25];
    for (int k = 0; k < 24; k++) sum += got[k];
    chk("invariant", got[24], sum);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
